// File: rtl/fetch_pkg.sv
// Shared types and encodings for the instruction-fetch sequencing controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        RUN   = 2'b01,
        STALL = 2'b10,
        HALT  = 2'b11
    } state_t;

    localparam logic [1:0] PCSEL_SEQ  = 2'b00;
    localparam logic [1:0] PCSEL_BR   = 2'b01;
    localparam logic [1:0] PCSEL_JIMM = 2'b10;
    localparam logic [1:0] PCSEL_JREG = 2'b11;

    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_IMM  = 2'b01;
    localparam logic [1:0] JMP_REG  = 2'b10;

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// W-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count events, holding at the maximum value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: boot window, stall/redirect control, sticky halt.
// Optional statistics counters are built when FETCH_STATS_EN is defined.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int BOOT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             branch_taken,
    input  logic [1:0]       jmp,
    input  logic             load_use,
    input  logic             halt,
    output logic [1:0]       pc_sel,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
`ifdef FETCH_STATS_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`endif
    output logic [1:0]       state_o
);

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    state_t     state_r;
    state_t     next_state_s;
    logic [3:0] boot_cnt_r;

    assign state_o = state_r;

    // Mealy outputs and next state; RUN and STALL share one priority chain.
    always_comb begin
        pc_sel       = PCSEL_SEQ;
        pc_write     = 1'b0;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b1;
        next_state_s = state_r;
        case (state_r)
            BOOT: begin
                if (boot_cnt_r == BOOT_LAST) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = BOOT;
                end
            end
            RUN, STALL: begin
                if (halt) begin
                    next_state_s = HALT;
                end else if (load_use) begin
                    // Redirects are dropped here and reappear once the stall clears.
                    ifid_write   = 1'b0;
                    ifid_flush   = 1'b0;
                    next_state_s = STALL;
                end else begin
                    pc_write     = 1'b1;
                    next_state_s = RUN;
                    if (jmp == JMP_REG) begin
                        pc_sel = PCSEL_JREG;
                    end else if (jmp == JMP_IMM) begin
                        pc_sel = PCSEL_JIMM;
                    end else if (branch_taken) begin
                        pc_sel = PCSEL_BR;
                    end else begin
                        ifid_flush = 1'b0;
                    end
                end
            end
            HALT: begin
                ifid_write   = 1'b0;
                next_state_s = HALT;
            end
            default: begin
                next_state_s = BOOT;
            end
        endcase
    end

    // State register and boot-window counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= BOOT;
            boot_cnt_r <= 4'd0;
        end else begin
            state_r <= next_state_s;
            if (state_r == BOOT) begin
                boot_cnt_r <= boot_cnt_r + 4'd1;
            end else begin
                boot_cnt_r <= boot_cnt_r;
            end
        end
    end

`ifdef FETCH_STATS_EN
    logic active_s;
    logic stall_inc_s;
    logic flush_inc_s;

    assign active_s    = (state_r == RUN) || (state_r == STALL);
    assign stall_inc_s = active_s && !pc_write;
    assign flush_inc_s = active_s && pc_write && ifid_flush;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc_s),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc_s),
        .count (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl; counter checks are built with FETCH_STATS_EN.
module tb_fetch_ctrl;

    typedef struct packed {
        logic       rst;
        logic       br;
        logic [1:0] jmp;
        logic       lu;
        logic       halt;
        logic [6:0] exp;   // {pc_sel, pc_write, ifid_write, ifid_flush, state_o}
        logic [6:0] mask;
    } rec_t;

    localparam logic [6:0] M_ALL   = 7'b1111111;
    localparam logic [6:0] M_NOSEL = 7'b0011111;
    localparam logic [6:0] M_HREQ  = 7'b0010111;
    localparam logic [6:0] M_NONE  = 7'b0000000;

    localparam logic [6:0] E_BOOT   = 7'b00_0_1_1_00;
    localparam logic [6:0] E_IDLE   = 7'b00_1_1_0_01;
    localparam logic [6:0] E_BR     = 7'b01_1_1_1_01;
    localparam logic [6:0] E_JI     = 7'b10_1_1_1_01;
    localparam logic [6:0] E_JR     = 7'b11_1_1_1_01;
    localparam logic [6:0] E_LU_RUN = 7'b00_0_0_0_01;
    localparam logic [6:0] E_LU_STL = 7'b00_0_0_0_10;
    localparam logic [6:0] E_JI_STL = 7'b10_1_1_1_10;
    localparam logic [6:0] E_HQ_RUN = 7'b00_0_0_1_01;
    localparam logic [6:0] E_HQ_STL = 7'b00_0_0_1_10;
    localparam logic [6:0] E_HALTED = 7'b00_0_0_1_11;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       branch_taken = 1'b0;
    logic [1:0] jmp = 2'b00;
    logic       load_use = 1'b0;
    logic       halt = 1'b0;
    logic [1:0] pc_sel;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic [1:0] state_o;

    int   checks = 0;
    int   errors = 0;
    rec_t sb[$];
    rec_t prev;
    logic have_prev = 1'b0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    always #5 clk = ~clk;

`ifdef FETCH_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic [3:0]  stall_cnt4;
    logic [3:0]  flush_cnt4;
    logic [1:0]  pc_sel4;
    logic        pc_write4;
    logic        ifid_write4;
    logic        ifid_flush4;
    logic [1:0]  state_o4;

    fetch_ctrl #(.BOOT_CYCLES(2), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .branch_taken(branch_taken), .jmp(jmp),
        .load_use(load_use), .halt(halt), .pc_sel(pc_sel4), .pc_write(pc_write4),
        .ifid_write(ifid_write4), .ifid_flush(ifid_flush4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4), .state_o(state_o4)
    );
`endif

    fetch_ctrl #(.BOOT_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .branch_taken(branch_taken), .jmp(jmp),
        .load_use(load_use), .halt(halt), .pc_sel(pc_sel), .pc_write(pc_write),
        .ifid_write(ifid_write), .ifid_flush(ifid_flush),
`ifdef FETCH_STATS_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .state_o(state_o)
    );

    function automatic rec_t R(input logic r, input logic b, input logic [1:0] j,
                               input logic l, input logic h,
                               input logic [6:0] e, input logic [6:0] m);
        rec_t t;
        t.rst = r; t.br = b; t.jmp = j; t.lu = l; t.halt = h; t.exp = e; t.mask = m;
        return t;
    endfunction

    // One clock: account the previous cycle's counter effect, drive, queue the expectation.
    task automatic cycle(input rec_t t);
        @(posedge clk);
        if (have_prev) begin
            if (!prev.rst) begin
                exp_stall = 0;
                exp_flush = 0;
            end else if (prev.exp[1:0] == 2'b01 || prev.exp[1:0] == 2'b10) begin
                if (!prev.exp[4]) exp_stall++;
                else if (prev.exp[2]) exp_flush++;
            end
        end
        #1;
        rst = t.rst; branch_taken = t.br; jmp = t.jmp; load_use = t.lu; halt = t.halt;
        sb.push_back(t);
        prev = t;
        have_prev = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rec_t tab[$];
        rec_t e;
        logic [6:0] got;
        tab = '{R(0,0,2'b00,0,0,E_BOOT,M_ALL), R(0,1,2'b10,0,0,E_BOOT,M_ALL),
                R(0,0,2'b00,1,1,E_BOOT,M_ALL), R(1,1,2'b10,1,1,E_BOOT,M_ALL),
                R(1,1,2'b01,0,0,E_BOOT,M_ALL), R(1,0,2'b00,0,0,E_IDLE,M_ALL)};
        foreach (tab[i]) begin
            cycle(tab[i]);
            e = sb.pop_front();
            got = {pc_sel, pc_write, ifid_write, ifid_flush, state_o};
            if (e.mask != M_NONE) begin
                checks++;
                if ((got & e.mask) !== (e.exp & e.mask)) begin
                    errors++;
                    $display("FAIL reset[%0d]: got %b expected %b mask %b", i, got, e.exp, e.mask);
                end
            end
        end
    endtask

    task automatic test_branch();
        rec_t tab[$];
        rec_t e;
        logic [6:0] got;
        tab = '{R(1,1,2'b00,0,0,E_BR,M_ALL), R(1,0,2'b00,0,0,E_IDLE,M_ALL)};
        foreach (tab[i]) begin
            cycle(tab[i]);
            e = sb.pop_front();
            got = {pc_sel, pc_write, ifid_write, ifid_flush, state_o};
            checks++;
            if ((got & e.mask) !== (e.exp & e.mask)) begin
                errors++;
                $display("FAIL branch[%0d]: got %b expected %b", i, got, e.exp);
            end
        end
`ifdef FETCH_STATS_EN
        checks++;
        if (flush_cnt !== 16'(exp_flush)) begin
            errors++;
            $display("FAIL branch_flush_cnt: got %0d expected %0d", flush_cnt, exp_flush);
        end
`endif
    endtask

    task automatic test_jump_priority();
        rec_t tab[$];
        rec_t e;
        logic [6:0] got;
        tab = '{R(1,1,2'b10,0,0,E_JR,M_ALL), R(1,1,2'b01,0,0,E_JI,M_ALL),
                R(1,1,2'b11,0,0,E_BR,M_ALL), R(1,0,2'b11,0,0,E_IDLE,M_ALL),
                R(1,0,2'b10,0,0,E_JR,M_ALL), R(1,0,2'b00,0,0,E_IDLE,M_ALL)};
        foreach (tab[i]) begin
            cycle(tab[i]);
            e = sb.pop_front();
            got = {pc_sel, pc_write, ifid_write, ifid_flush, state_o};
            checks++;
            if ((got & e.mask) !== (e.exp & e.mask)) begin
                errors++;
                $display("FAIL jump_prio[%0d]: got %b expected %b", i, got, e.exp);
            end
        end
    endtask

    task automatic test_stall();
        rec_t tab[$];
        rec_t e;
        logic [6:0] got;
        tab = '{R(1,0,2'b01,1,0,E_LU_RUN,M_NOSEL), R(1,1,2'b01,1,0,E_LU_STL,M_NOSEL),
                R(1,0,2'b01,0,0,E_JI_STL,M_ALL), R(1,0,2'b00,0,0,E_IDLE,M_ALL)};
        foreach (tab[i]) begin
            cycle(tab[i]);
            e = sb.pop_front();
            got = {pc_sel, pc_write, ifid_write, ifid_flush, state_o};
            checks++;
            if ((got & e.mask) !== (e.exp & e.mask)) begin
                errors++;
                $display("FAIL stall[%0d]: got %b expected %b", i, got, e.exp);
            end
        end
`ifdef FETCH_STATS_EN
        checks++;
        if (stall_cnt !== 16'(exp_stall)) begin
            errors++;
            $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, exp_stall);
        end
`endif
    endtask

    task automatic test_stall_halt();
        rec_t tab[$];
        rec_t e;
        logic [6:0] got;
        tab = '{R(1,0,2'b00,1,0,E_LU_RUN,M_NOSEL), R(1,0,2'b10,1,1,E_HQ_STL,M_HREQ),
                R(1,1,2'b01,1,0,E_HALTED,M_ALL),   R(1,0,2'b10,0,1,E_HALTED,M_ALL),
                R(1,1,2'b11,0,0,E_HALTED,M_ALL),   R(0,0,2'b00,0,0,E_BOOT,M_NONE),
                R(0,0,2'b00,0,0,E_BOOT,M_ALL),     R(1,0,2'b00,0,0,E_BOOT,M_ALL),
                R(1,0,2'b00,0,0,E_BOOT,M_ALL),     R(1,0,2'b00,0,0,E_IDLE,M_ALL)};
        foreach (tab[i]) begin
            cycle(tab[i]);
            e = sb.pop_front();
            got = {pc_sel, pc_write, ifid_write, ifid_flush, state_o};
            if (e.mask != M_NONE) begin
                checks++;
                if ((got & e.mask) !== (e.exp & e.mask)) begin
                    errors++;
                    $display("FAIL stall_halt[%0d]: got %b expected %b", i, got, e.exp);
                end
            end
        end
    endtask

    task automatic test_reset_midstall();
        rec_t tab[$];
        rec_t e;
        logic [6:0] got;
        tab = '{R(1,0,2'b00,1,0,E_LU_RUN,M_NOSEL), R(1,0,2'b00,1,0,E_LU_STL,M_NOSEL),
                R(0,0,2'b00,1,0,E_BOOT,M_NONE),    R(0,0,2'b01,1,0,E_BOOT,M_ALL),
                R(1,0,2'b00,1,0,E_BOOT,M_ALL),     R(1,0,2'b00,0,0,E_BOOT,M_ALL),
                R(1,0,2'b00,0,0,E_IDLE,M_ALL)};
        foreach (tab[i]) begin
            cycle(tab[i]);
            e = sb.pop_front();
            got = {pc_sel, pc_write, ifid_write, ifid_flush, state_o};
            if (e.mask != M_NONE) begin
                checks++;
                if ((got & e.mask) !== (e.exp & e.mask)) begin
                    errors++;
                    $display("FAIL reset_midstall[%0d]: got %b expected %b", i, got, e.exp);
                end
            end
        end
`ifdef FETCH_STATS_EN
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midstall_cnt_clear: got %0d expected 0", stall_cnt);
        end
`endif
    endtask

    task automatic test_halt();
        rec_t tab[$];
        rec_t e;
        logic [6:0] got;
        tab = '{R(1,0,2'b00,0,1,E_HQ_RUN,M_HREQ), R(1,1,2'b10,0,0,E_HALTED,M_ALL),
                R(1,0,2'b01,1,0,E_HALTED,M_ALL),  R(1,1,2'b00,0,1,E_HALTED,M_ALL),
                R(0,0,2'b00,0,0,E_BOOT,M_NONE),   R(0,0,2'b00,0,0,E_BOOT,M_ALL),
                R(1,0,2'b00,0,0,E_BOOT,M_ALL),    R(1,0,2'b00,0,0,E_BOOT,M_ALL),
                R(1,0,2'b00,0,0,E_IDLE,M_ALL)};
        foreach (tab[i]) begin
            cycle(tab[i]);
            e = sb.pop_front();
            got = {pc_sel, pc_write, ifid_write, ifid_flush, state_o};
            if (e.mask != M_NONE) begin
                checks++;
                if ((got & e.mask) !== (e.exp & e.mask)) begin
                    errors++;
                    $display("FAIL halt[%0d]: got %b expected %b", i, got, e.exp);
                end
            end
        end
    endtask

`ifdef FETCH_STATS_EN
    task automatic test_saturation();
        rec_t e;
        logic [6:0] got;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) cycle(R(1,1,2'b00,0,0,E_BR,M_ALL));
            else            cycle(R(1,0,2'b01,0,0,E_JI,M_ALL));
            e = sb.pop_front();
            got = {pc_sel, pc_write, ifid_write, ifid_flush, state_o};
            checks++;
            if ((got & e.mask) !== (e.exp & e.mask)) begin
                errors++;
                $display("FAIL saturation[%0d]: got %b expected %b", i, got, e.exp);
            end
        end
        cycle(R(1,0,2'b00,0,0,E_IDLE,M_ALL));
        e = sb.pop_front();
        checks++;
        if (flush_cnt4 !== 4'd15) begin
            errors++;
            $display("FAIL flush_cnt_sat4: got %0d expected 15", flush_cnt4);
        end
        checks++;
        if (flush_cnt !== 16'(exp_flush)) begin
            errors++;
            $display("FAIL flush_cnt_wide: got %0d expected %0d", flush_cnt, exp_flush);
        end
    endtask
`endif

    // Run every scenario in sequence, then report.
    initial begin
        test_reset();
        test_branch();
        test_jump_priority();
        test_stall();
        test_stall_halt();
        test_reset_midstall();
        test_halt();
`ifdef FETCH_STATS_EN
        test_saturation();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the instruction-fetch stage of the MIPS pipeline. It selects the next-PC source, gates the PC and IF/ID register writes, and inserts a bubble into IF/ID on control-flow redirects. It also sequences the post-reset boot window and a sticky halt. It sits between the ID-stage control/hazard logic and the fetch datapath.

## Interface
Parameters:
- BOOT_CYCLES, 2: cycles after reset release during which the PC is held and IF/ID is flushed; legal range 1..15.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-low (0 = reset)
- branch_taken  input  1  branch condition AND branch control from ID
- jmp  input  2  jump type from ID: 00 none, 01 jump-immediate, 10 jump-register, 11 reserved (treated as 00)
- load_use  input  1  load-use hazard detected for the instruction in ID
- halt  input  1  halt request from ID (syscall/break)
- pc_sel  output  2  next-PC mux select: 00 PC+4, 01 branch target, 10 jump-immediate target, 11 register target
- pc_write  output  1  PC load enable
- ifid_write  output  1  IF/ID register load enable
- ifid_flush  output  1  load a NOP into IF/ID on this edge
- state_o  output  2  current FSM state encoding
- stall_cnt, flush_cnt  output  CNT_W  statistics counters, present only with FETCH_STATS_EN

## Operation
- FSM states: BOOT=00, RUN=01, STALL=10, HALT=11.
- BOOT: pc_sel=00, pc_write=0, ifid_write=1, ifid_flush=1. A boot counter counts BOOT_CYCLES cycles, then the FSM goes to RUN. All inputs are ignored.
- RUN, priority order:
  1. halt=1: FSM goes to HALT. pc_write=0, ifid_flush=1.
  2. load_use=1: FSM goes to STALL. pc_write=0, ifid_write=0, ifid_flush=0. Any jmp or branch_taken presented in this cycle is suppressed and is re-evaluated when the stall ends.
  3. jmp=10: pc_sel=11.
  4. jmp=01: pc_sel=10.
  5. branch_taken=1: pc_sel=01.
  6. Otherwise: pc_sel=00.
  - For cases 3–5 (redirect): pc_write=1, ifid_write=1, ifid_flush=1.
  - For case 6: pc_write=1, ifid_write=1, ifid_flush=0.
- STALL: outputs are the same as RUN with its priority applied. The FSM stays in STALL while load_use=1 and returns to RUN when load_use=0. halt still has top priority.
- HALT: pc_write=0, ifid_write=0, ifid_flush=1, pc_sel=00. The state is sticky until rst=0.
- jmp and branch_taken both active: the jump wins. This is a protocol error upstream, but the behaviour is defined.
- jmp=11 is treated as no jump. branch_taken is still honoured.

## Timing
- State and counters are registered. pc_sel, pc_write, ifid_write and ifid_flush are combinational from the current state and current inputs (Mealy), so they are valid in the same cycle as the inputs.
- Redirect latency: the target is loaded into the PC on the edge ending the cycle in which the redirect is presented. Exactly one bubble is inserted into IF/ID, with no delay slot.
- Reset (rst=0 at an edge): the next state is BOOT and the boot counter is cleared.
  - While rst=0 and from the first edge, outputs show BOOT values: pc_write=0, ifid_flush=1, ifid_write=1, pc_sel=00, state_o=00.
  - Statistics counters reset to 0.
  - Reset asserted mid-stall or mid-halt behaves identically.
- First PC advance happens on the edge after BOOT_CYCLES cycles with rst=1.

## Configuration
- FETCH_STATS_EN defined:
  - stall_cnt increments in each cycle where pc_write=0 in RUN or STALL.
  - flush_cnt increments in each redirect cycle.
  - Both saturate at all-ones.
- FETCH_STATS_EN undefined: the counters, their ports and their logic are absent. Behaviour is otherwise identical.

## Structure
- Shared package fetch_pkg holds:
  - State enum: BOOT, RUN, STALL, HALT.
  - pc_sel constants: PCSEL_SEQ, PCSEL_BR, PCSEL_JIMM, PCSEL_JREG.
  - jmp constants: JMP_NONE, JMP_IMM, JMP_REG.
- The boot counter is inline. One natural sub-module: sat_counter (CNT_W-wide saturating counter), instantiated twice under FETCH_STATS_EN.

## Test plan
- Reset with BOOT_CYCLES=2: hold rst=0 for 3 cycles, then release → pc_write=0 for the 2 cycles after release; in the 3rd cycle, pc_write=1, state_o=01 and pc_sel=00.
- RUN with branch_taken=1 for one cycle → that cycle shows pc_sel=01 and ifid_flush=1; the next cycle shows pc_sel=00 and ifid_flush=0; flush_cnt=1.
- jmp=10 and branch_taken=1 together → pc_sel=11 and ifid_flush=1.
- load_use=1 for 2 cycles together with jmp=01 → pc_write=0 and ifid_write=0 for 2 cycles, state_o=10. Then jmp=01 with load_use=0 → pc_sel=10; stall_cnt=2.
- halt=1 in RUN → state_o=11 and pc_write=0 for all later cycles regardless of inputs; rst=0 → returns to BOOT.
- CNT_W=4 with 20 consecutive redirects → flush_cnt saturates at 15.
